// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit and the
// control-unit decode of its instructions.
package mult_div_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } md_state_t;

  // R-type funct codes decoded by the control unit.
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle 32-bit signed/unsigned multiply (shift-add) and divide (restoring)
// unit. Both share one 64-bit shift register and one 33-bit adder/subtractor.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        sign_quo_q;
  logic        sign_rem_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic [31:0] opnd_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        div_zero_q;

  logic        op_div;
  logic        op_signed;
  logic        zero_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] addsub_in;
  logic [32:0] addsub_y;
  logic [63:0] product;
  logic [63:0] product_fix;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign zero_div  = op_div && (b == 32'd0);
  assign mag_a     = op_signed ? abs32(a) : a;
  assign mag_b     = op_signed ? abs32(b) : b;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = zero_div ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 5'(MD_ITER - 1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Multiply adds the multiplicand to the upper half; divide subtracts the
  // divisor from the remainder with the next dividend bit shifted in.
  always_comb begin
    addsub_in = is_div_q ? {acc_hi_q, acc_lo_q[31]} : {1'b0, acc_hi_q};
    addsub_y  = is_div_q ? (addsub_in - {1'b0, opnd_q}) : (addsub_in + {1'b0, opnd_q});
    product     = {acc_hi_q, acc_lo_q};
    product_fix = sign_quo_q ? (~product + 64'd1) : product;
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      opnd_q     <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (zero_div) begin
              div_zero_q <= 1'b1;
            end else begin
              div_zero_q <= 1'b0;
              cnt_q      <= 5'd0;
              is_div_q   <= op_div;
              sign_quo_q <= op_signed & (a[31] ^ b[31]);
              sign_rem_q <= op_signed & a[31];
              acc_hi_q   <= 32'd0;
              // Low half holds the dividend (divide) or the multiplier (multiply).
              acc_lo_q   <= op_div ? mag_a : mag_b;
              opnd_q     <= op_div ? mag_b : mag_a;
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + 5'd1;
          if (is_div_q) begin
            if (!addsub_y[32]) begin
              acc_hi_q <= addsub_y[31:0];
              acc_lo_q <= {acc_lo_q[30:0], 1'b1};
            end else begin
              acc_hi_q <= addsub_in[31:0];
              acc_lo_q <= {acc_lo_q[30:0], 1'b0};
            end
          end else begin
            if (acc_lo_q[0]) begin
              {acc_hi_q, acc_lo_q} <= {addsub_y, acc_lo_q[31:1]};
            end else begin
              {acc_hi_q, acc_lo_q} <= {1'b0, acc_hi_q, acc_lo_q[31:1]};
            end
          end
        end
        StFix: begin
          if (is_div_q) begin
            lo_q <= sign_quo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
            hi_q <= sign_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
          end else begin
            hi_q <= product_fix[63:32];
            lo_q <= product_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
